uart_tx_frame_serializer: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_serializer.sv | 40 ++++
 rtl/uart_tx_frame_serializer.sv | 128 ++++++++++++
 tb/tb_uart_tx_frame_serializer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register and bit counter for the UART data bits (LSB first).
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ser_bit,
    output logic                  o_ser_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] r_sr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_done;

    assign w_done     = (r_cnt == CNT_W'(DATA_WIDTH - 1));
    assign o_ser_bit  = r_sr[0];
    assign o_ser_done = w_done;

    // Counter saturates at the last data bit so it never wraps.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sr  <= i_data;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sr <= {1'b0, r_sr[DATA_WIDTH-1:1]};
            if (!w_done) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART transmitter: start, LSB-first data, optional parity, stop.
// Define UART_TX_TWO_STOP_EN for two stop bits.
module uart_tx_frame_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_p_data,
    input  logic                  i_data_valid,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic                  o_tx_out,
    output logic                  o_busy
);

    tx_state_t r_state;
    tx_state_t w_next;
    logic      r_par_en;
    logic      r_par;
    logic      r_tx;
    logic      r_busy;
    logic      w_tx;
    logic      w_busy;
    logic      w_load;
    logic      w_shift;
    logic      w_ser_bit;
    logic      w_ser_done;
`ifdef UART_TX_TWO_STOP_EN
    logic      r_stop_cnt;
`endif

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_data     (i_p_data),
        .o_ser_bit  (w_ser_bit),
        .o_ser_done (w_ser_done)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_tx    = LINE_IDLE;
        w_busy  = 1'b1;
        w_load  = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (i_data_valid) begin
                    w_load = 1'b1;
                    w_next = START;
                end
            end
            START: begin
                w_tx   = 1'b0;
                w_next = DATA;
            end
            DATA: begin
                w_tx    = w_ser_bit;
                w_shift = 1'b1;
                if (w_ser_done) begin
                    w_next = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                w_tx   = r_par;
                w_next = STOP;
            end
            STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                w_next = r_stop_cnt ? IDLE : STOP;
`else
                w_next = IDLE;
`endif
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Line and busy are registered from the current state's outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tx     <= LINE_IDLE;
            r_busy   <= 1'b0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
        end else begin
            r_tx   <= w_tx;
            r_busy <= w_busy;
            if (w_load) begin
                r_par_en <= i_par_en;
                r_par    <= (^i_p_data) ^ (i_par_typ == PAR_ODD);
            end
        end
    end

`ifdef UART_TX_TWO_STOP_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stop_cnt <= 1'b0;
        end else if (r_state == STOP) begin
            r_stop_cnt <= ~r_stop_cnt;
        end else begin
            r_stop_cnt <= 1'b0;
        end
    end
`endif

    assign o_tx_out = r_tx;
    assign o_busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Self-checking bench for uart_tx_frame_serializer (scoreboard of line bits).
module tb_uart_tx_frame_serializer;

    logic       i_clk;
    logic       i_rst_n;
    logic [7:0] i_p_data;
    logic       i_data_valid;
    logic       i_par_en;
    logic       i_par_typ;
    logic       o_tx_out;
    logic       o_busy;

    int n_cmp;
    int n_err;
    logic exp_q[$];

    uart_tx_frame_serializer #(
        .DATA_WIDTH(8)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_p_data     (i_p_data),
        .i_data_valid (i_data_valid),
        .i_par_en     (i_par_en),
        .i_par_typ    (i_par_typ),
        .o_tx_out     (o_tx_out),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic push_frame(input logic [7:0] d, input logic pe,
                              input logic pt);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back((^d) ^ pt);
        exp_q.push_back(1'b1);
`ifdef UART_TX_TWO_STOP_EN
        exp_q.push_back(1'b1);
`endif
    endtask

    // Returns just after the edge that samples valid.
    task automatic start_frame(input logic [7:0] d, input logic pe,
                               input logic pt);
        @(negedge i_clk);
        i_p_data     = d;
        i_par_en     = pe;
        i_par_typ    = pt;
        i_data_valid = 1'b1;
        push_frame(d, pe, pt);
        @(posedge i_clk);
        #1;
        i_data_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge i_clk);
        i_rst_n      = 1'b0;
        i_data_valid = 1'b1;
        i_p_data     = 8'h5A;
        @(posedge i_clk);
        #1;
        n_cmp++;
        if (o_tx_out !== 1'b1 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset: tx=%b busy=%b want tx=1 busy=0",
                     o_tx_out, o_busy);
        end
        @(negedge i_clk);
        i_rst_n      = 1'b1;
        i_data_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge i_clk);
            #1;
            n_cmp++;
            if (o_tx_out !== 1'b1 || o_busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle[%0d]: tx=%b busy=%b want 1/0",
                         k, o_tx_out, o_busy);
            end
        end
    endtask

    task automatic test_frame(input string nm, input logic [7:0] d,
                              input logic pe, input logic pt);
        int k;
        logic b;
        start_frame(d, pe, pt);
        k = 0;
        while (exp_q.size() > 0) begin
            @(posedge i_clk);
            #1;
            b = exp_q.pop_front();
            n_cmp++;
            if (o_tx_out !== b || o_busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s bit%0d: tx=%b busy=%b want tx=%b busy=1",
                         nm, k, o_tx_out, o_busy, b);
            end
            k++;
        end
        @(posedge i_clk);
        #1;
        n_cmp++;
        if (o_tx_out !== 1'b1 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle: tx=%b busy=%b want 1/0",
                     nm, o_tx_out, o_busy);
        end
    endtask

    task automatic test_ignore_busy;
        int k;
        logic b;
        start_frame(8'h3C, 1'b0, 1'b0);
        k = 0;
        while (exp_q.size() > 0) begin
            @(posedge i_clk);
            #1;
            i_data_valid = 1'b0;
            b = exp_q.pop_front();
            n_cmp++;
            if (o_tx_out !== b || o_busy !== 1'b1) begin
                n_err++;
                $display("FAIL ignore bit%0d: tx=%b busy=%b want tx=%b busy=1",
                         k, o_tx_out, o_busy, b);
            end
            if (k == 3) begin
                i_p_data     = 8'hFF;
                i_data_valid = 1'b1;
            end
            k++;
        end
        for (int j = 0; j < 3; j++) begin
            @(posedge i_clk);
            #1;
            n_cmp++;
            if (o_tx_out !== 1'b1 || o_busy !== 1'b0) begin
                n_err++;
                $display("FAIL ignore idle%0d: tx=%b busy=%b want 1/0",
                         j, o_tx_out, o_busy);
            end
        end
    endtask

    task automatic test_cfg_change;
        int k;
        logic b;
        start_frame(8'hC3, 1'b1, 1'b0);
        i_p_data  = 8'h00;
        i_par_en  = 1'b0;
        i_par_typ = 1'b1;
        k = 0;
        while (exp_q.size() > 0) begin
            @(posedge i_clk);
            #1;
            b = exp_q.pop_front();
            n_cmp++;
            if (o_tx_out !== b || o_busy !== 1'b1) begin
                n_err++;
                $display("FAIL cfgchg bit%0d: tx=%b busy=%b want tx=%b busy=1",
                         k, o_tx_out, o_busy, b);
            end
            k++;
        end
    endtask

    task automatic test_back_to_back;
        int k;
        logic b;
        for (int f = 0; f < 2; f++) begin
            @(negedge i_clk);
            i_p_data     = (f == 0) ? 8'h96 : 8'h4D;
            i_par_en     = f[0];
            i_par_typ    = 1'b1;
            i_data_valid = 1'b1;
            push_frame(i_p_data, i_par_en, i_par_typ);
            @(posedge i_clk);
            #1;
            i_data_valid = 1'b0;
            k = 0;
            while (exp_q.size() > 0) begin
                @(posedge i_clk);
                #1;
                b = exp_q.pop_front();
                n_cmp++;
                if (o_tx_out !== b || o_busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b f%0d bit%0d: tx=%b busy=%b want tx=%b busy=1",
                             f, k, o_tx_out, o_busy, b);
                end
                k++;
            end
        end
    endtask

    task automatic test_reset_mid;
        int k;
        logic b;
        start_frame(8'h81, 1'b0, 1'b0);
        k = 0;
        while (exp_q.size() > 0) begin
            @(posedge i_clk);
            #1;
            b = exp_q.pop_front();
            n_cmp++;
            if (o_tx_out !== b || o_busy !== 1'b1) begin
                n_err++;
                $display("FAIL rstmid bit%0d: tx=%b busy=%b want tx=%b busy=1",
                         k, o_tx_out, o_busy, b);
            end
            if (k == 4) begin
                i_rst_n = 1'b0;
                exp_q.delete();
            end
            k++;
        end
        @(posedge i_clk);
        #1;
        n_cmp++;
        if (o_tx_out !== 1'b1 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid abort: tx=%b busy=%b want 1/0",
                     o_tx_out, o_busy);
        end
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        n_cmp++;
        if (o_tx_out !== 1'b1 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid idle: tx=%b busy=%b want 1/0",
                     o_tx_out, o_busy);
        end
        test_frame("rstmid_again", 8'h81, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        i_rst_n      = 1'b0;
        i_p_data     = 8'h00;
        i_data_valid = 1'b0;
        i_par_en     = 1'b0;
        i_par_typ    = 1'b0;
        repeat (2) @(posedge i_clk);
        test_reset();
        test_frame("nopar_A5", 8'hA5, 1'b0, 1'b0);
        test_frame("even_A5", 8'hA5, 1'b1, 1'b0);
        test_frame("odd_00", 8'h00, 1'b1, 1'b1);
        test_frame("odd_A7", 8'hA7, 1'b1, 1'b1);
        test_frame("even_FF", 8'hFF, 1'b1, 1'b0);
        test_frame("stop2_55", 8'h55, 1'b0, 1'b0);
        test_ignore_busy();
        test_cfg_change();
        test_back_to_back();
        test_reset_mid();
        for (int r = 0; r < 4; r++) begin
            test_frame("rand", 8'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
